tile_pixel_pipeline: RTL and testbench
======================================

// Module: tile_pixel_pipeline
// PURPOSE
//  Scanline renderer stage that sits directly upstream of TileMap and consumes its output.
//  - Takes raster position plus syncs from the video timing generator.
//  - Applies frame-latched X/Y scroll with wrap-around.
//  - Drives TileMap tile indices and uses the returned texture index to address the texture ROM.
//  - Emits a registered RGB pixel with sync/DE delayed to match.
//  - Tiles are fixed at 16x16 px; the map is 40x30 tiles.
// PARAMETERS
//  MAP_W_PX    640  map width in pixels; wrap modulus for X (must be 40*16)
//  MAP_H_PX    480  map height in pixels; wrap modulus for Y (must be 30*16)
//  TEX_DATA_W  12   texel/pixel width (RGB444)
// PORTS
//  clk                    in   1       system clock
//  rst_n                  in   1       asynchronous reset, active-low
//  i_pix_x                in   10      raster X; < MAP_W_PX while i_de=1
//  i_pix_y                in   10      raster Y; < MAP_H_PX while i_de=1
//  i_de                   in   1       display enable
//  i_hsync                in   1       hsync, passed through delayed
//  i_vsync                in   1       vsync, active-high; rising edge = frame boundary
//  o_tilemap_x_idx        out  6       tile column to TileMap (0..39)
//  o_tilemap_y_idx        out  6       tile row to TileMap (0..29)
//  i_tilemap_texture_idx  in   8       TileMap result, valid 1 cycle after idx
//  o_tex_addr             out  16      texture ROM address {tex_idx, ty[3:0], tx[3:0]}
//  i_tex_data             in   TEX_DATA_W  ROM texel, valid 1 cycle after o_tex_addr
//  o_pixel                out  TEX_DATA_W  output pixel
//  o_de/o_hsync/o_vsync   out  1       delayed DE/syncs, aligned with o_pixel
//  i_wdata                in   32      register write data
//  i_wea                  in   1       register write strobe (already chip-selected)
//  i_wselect              in   4       byte enables; only 4'hF is accepted
//  i_waddr                in   27      word select is i_waddr[3:2]
// BEHAVIOUR
//  - Reset (async, rst_n=0): all pipeline flops, outputs, shadow and active scroll regs go to 0; ctrl.enable=1; bg=0.
//    Outputs are 0 immediately.
//    After release the first valid pixel appears LAT=5 cycles after its first sample; no garbage with o_de=1.
//  - Registers (write only when i_wea && i_wselect==4'hF; partial writes ignored):
//    - 0: scroll_x shadow = wdata[9:0]; write dropped if >= MAP_W_PX.
//    - 1: scroll_y shadow = wdata[9:0]; write dropped if >= MAP_H_PX.
//    - 2: ctrl: bit0 enable, bits[27:16] bg colour; takes effect immediately.
//    - 3: ignored.
//  - Frame latch: on the cycle i_vsync is 1 and was 0 the previous cycle, active scroll <= shadow.
//    - Write in the same cycle: active takes the OLD shadow; the new value applies at the next frame.
//  - Pipeline (edge k = k-th rising edge after inputs are presented):
//    - E1: wx = px + scroll_x (11b); if wx >= MAP_W_PX, wx -= MAP_W_PX; wy likewise with MAP_H_PX.
//      o_tilemap_x_idx = wx[9:4], o_tilemap_y_idx = wy[9:4] (registered); carry tx=wx[3:0], ty=wy[3:0].
//    - E2: TileMap BRAM samples idx; i_tilemap_texture_idx is valid in the following cycle.
//    - E3: o_tex_addr <= {i_tilemap_texture_idx, ty, tx} (registered).
//    - E4: texture ROM samples; i_tex_data is valid in the following cycle.
//    - E5: o_pixel <= !de_d ? 0 : (!enable ? bg : i_tex_data).
//      o_de/o_hsync/o_vsync are 5-deep delayed copies.
//    - Total latency 5 cycles, throughput 1 px/clk, no stalls; i_de=0 still advances the pipe.
//  - Wrap: wx,wy always in range by construction; X wraps at 639->0, Y wraps at 479->0.
//  - Scroll changes never tear within a frame; enable/bg changes may take effect mid-line.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> o_pixel=0, o_de=0, idx=0, o_tex_addr=0 asynchronously.
//     Release -> first o_de=1 exactly 5 clk after the first i_de=1 sample.
//  2. Scroll 0, px=(17,33), TileMap model returns 0x5A -> o_tilemap idx=(1,2) after E1;
//     o_tex_addr=0x5A11 after E3; o_pixel=ROM[0x5A11] after E5.
//  3. Write scroll_x=630, scroll_y=475, then vsync rise; px=(15,10) -> wx=5, wy=5 -> idx=(0,0),
//     o_tex_addr low byte=0x55.
//  4. Write scroll_x=640 -> dropped, shadow unchanged.
//     Write with i_wselect=4'h3 -> ignored.
//     Write scroll_x=8 in the same cycle as vsync rise -> active=old value this frame, 8 next frame.
//  5. ctrl=enable 0, bg=0xF0A -> every o_de=1 pixel = 0xF0A.
//     With i_de=0 -> o_pixel=0 regardless of enable.
//  6. Full 640x480 frame scroll sweep vs reference model: pixel-exact match;
//     syncs aligned with o_pixel at 5-cycle delay.

Source files
------------

// File: rtl/tile_pixel_pipeline_if.sv
// tile_pixel_pipeline_if: register write bus into the tile pixel pipeline
interface tile_pixel_pipeline_if;
  logic [31:0] wdata;
  logic        wea;
  logic [3:0]  wselect;
  logic [26:0] waddr;
  modport master(output wdata, wea, wselect, waddr);
  modport slave(input wdata, wea, wselect, waddr);
endinterface

// File: rtl/tile_pixel_pipeline.sv
// tile_pixel_pipeline: scrolled tile map lookup, texture fetch and RGB pixel output with 5-cycle latency
module tile_pixel_pipeline #(
  parameter int MAP_W_PX   = 640,
  parameter int MAP_H_PX   = 480,
  parameter int TEX_DATA_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            i_pix_x,
  input  logic [9:0]            i_pix_y,
  input  logic                  i_de,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  output logic [5:0]            o_tilemap_x_idx,
  output logic [5:0]            o_tilemap_y_idx,
  input  logic [7:0]            i_tilemap_texture_idx,
  output logic [15:0]           o_tex_addr,
  input  logic [TEX_DATA_W-1:0] i_tex_data,
  output logic [TEX_DATA_W-1:0] o_pixel,
  output logic                  o_de,
  output logic                  o_hsync,
  output logic                  o_vsync,
  tile_pixel_pipeline_if.slave  regs
);
  localparam logic [10:0] W11 = 11'(MAP_W_PX);
  localparam logic [10:0] H11 = 11'(MAP_H_PX);
  logic [9:0]            shadow_x, shadow_y, scroll_x, scroll_y;
  logic                  enable, vsync_q, frame, wr_ok, unused_bits;
  logic [TEX_DATA_W-1:0] bg;
  logic [10:0]           sum_x, sum_y, wx, wy;
  logic [7:0]            txy_1, txy_2;
  logic [11:0]           sync_d;
  assign wr_ok = regs.wea && regs.wselect == 4'hF;
  assign frame = i_vsync && !vsync_q;
  // one conditional subtract suffices: both addends are below the modulus
  assign sum_x = {1'b0, i_pix_x} + {1'b0, scroll_x};
  assign sum_y = {1'b0, i_pix_y} + {1'b0, scroll_y};
  assign wx = sum_x >= W11 ? sum_x - W11 : sum_x;
  assign wy = sum_y >= H11 ? sum_y - H11 : sum_y;
  assign unused_bits = ^{regs.wdata[31:28], regs.wdata[15:10], regs.waddr[26:4], regs.waddr[1:0], wx[10], wy[10]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_x <= '0;
      shadow_y <= '0;
      scroll_x <= '0;
      scroll_y <= '0;
      enable   <= 1'b1;
      bg       <= '0;
      vsync_q  <= 1'b0;
    end else begin
      if (wr_ok && regs.waddr[3:2] == 2'd0 && regs.wdata[9:0] < W11[9:0]) shadow_x <= regs.wdata[9:0];
      if (wr_ok && regs.waddr[3:2] == 2'd1 && regs.wdata[9:0] < H11[9:0]) shadow_y <= regs.wdata[9:0];
      if (wr_ok && regs.waddr[3:2] == 2'd2) begin
        enable <= regs.wdata[0];
        bg     <= regs.wdata[16 +: TEX_DATA_W];
      end
      vsync_q <= i_vsync;
      // active scroll takes the pre-write shadow when a write lands on the frame edge
      if (frame) begin
        scroll_x <= shadow_x;
        scroll_y <= shadow_y;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tilemap_x_idx <= '0;
      o_tilemap_y_idx <= '0;
      txy_1           <= '0;
      txy_2           <= '0;
      o_tex_addr      <= '0;
      sync_d          <= '0;
      o_de            <= 1'b0;
      o_hsync         <= 1'b0;
      o_vsync         <= 1'b0;
      o_pixel         <= '0;
    end else begin
      o_tilemap_x_idx <= wx[9:4];
      o_tilemap_y_idx <= wy[9:4];
      txy_1           <= {wy[3:0], wx[3:0]};
      txy_2           <= txy_1;
      o_tex_addr      <= {i_tilemap_texture_idx, txy_2};
      sync_d          <= {sync_d[8:0], i_de, i_hsync, i_vsync};
      {o_de, o_hsync, o_vsync} <= sync_d[11:9];
      o_pixel         <= !sync_d[11] ? '0 : !enable ? bg : i_tex_data;
    end
  end
endmodule

// File: tb/tb_tile_pixel_pipeline.sv
// tb_tile_pixel_pipeline: random raster stream against a transaction-level model plus literal spot checks
module tb_tile_pixel_pipeline;
  typedef struct packed {
    logic        de, hs, vs;
    logic [5:0]  ix, iy;
    logic [15:0] addr;
  } ent_t;
  localparam logic [42:0] M_IDX = {12'hFFF, 31'h0};
  localparam logic [42:0] M_ADDR = {12'h0, 16'hFFFF, 15'h0};
  localparam logic [42:0] M_ALO = {12'h0, 16'h00FF, 15'h0};
  localparam logic [42:0] M_PD = {28'h0, 12'hFFF, 3'b100};
  localparam logic [42:0] M_DE = 43'b100;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [9:0]  px = '0, py = '0;
  logic        de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [5:0]  xi, yi;
  logic [7:0]  tex_idx;
  logic [15:0] tex_addr;
  logic [11:0] tex_data, pix;
  logic        ode, ohs, ovs;
  int          n_chk = 0, n_fail = 0;
  logic        lit_on = 1'b0;
  string       lit_nm = "";
  logic [42:0] lit_m = '0, lit_x = '0, act_v, exp_v;
  ent_t        h [4];
  ent_t        cur;
  logic [9:0]  shx, shy, acx, acy;
  logic        en, pvs;
  logic [11:0] bg;
  logic [5:0]  ex, ey;
  logic [15:0] ea;
  logic [11:0] ep;
  logic        ede, ehs, evs;
  tile_pixel_pipeline_if bus();
  always #5 clk = ~clk;
  tile_pixel_pipeline dut (
    .clk(clk), .rst_n(rst_n), .i_pix_x(px), .i_pix_y(py), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .o_tilemap_x_idx(xi), .o_tilemap_y_idx(yi), .i_tilemap_texture_idx(tex_idx),
    .o_tex_addr(tex_addr), .i_tex_data(tex_data), .o_pixel(pix),
    .o_de(ode), .o_hsync(ohs), .o_vsync(ovs), .regs(bus)
  );
  function automatic logic [7:0] tm(input logic [5:0] x, input logic [5:0] y);
    return 8'(int'(x) * 3 + int'(y) * 37 + 13);
  endfunction
  function automatic logic [11:0] rom(input logic [15:0] a);
    return a[11:0] ^ a[15:4];
  endfunction
  // pixel -> scrolled world position -> tile/texel coordinates, straight from the wrap rule
  function automatic ent_t mk(input logic [9:0] x, y, sx, sy, input logic d, hh, vv);
    int wx, wy;
    ent_t e;
    wx = int'(x) + int'(sx);
    wy = int'(y) + int'(sy);
    if (wx >= 640) wx -= 640;
    if (wy >= 480) wy -= 480;
    e.de = d;
    e.hs = hh;
    e.vs = vv;
    e.ix = 6'(wx >> 4);
    e.iy = 6'(wy >> 4);
    e.addr = {tm(e.ix, e.iy), 4'(wy), 4'(wx)};
    return e;
  endfunction
  always_ff @(posedge clk) begin
    tex_idx  <= tm(xi, yi);
    tex_data <= rom(tex_addr);
  end
  assign cur = mk(px, py, acx, acy, de, hs, vs);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) h[i] <= mk(10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      {shx, shy, acx, acy} <= '0;
      en  <= 1'b1;
      bg  <= '0;
      pvs <= 1'b0;
      {ex, ey, ea, ep, ede, ehs, evs} <= '0;
    end else begin
      h[0] <= cur;
      h[1] <= h[0];
      h[2] <= h[1];
      h[3] <= h[2];
      ex   <= cur.ix;
      ey   <= cur.iy;
      ea   <= h[1].addr;
      ep   <= !h[3].de ? 12'h0 : (!en ? bg : rom(h[3].addr));
      {ede, ehs, evs} <= {h[3].de, h[3].hs, h[3].vs};
      pvs <= vs;
      if (vs && !pvs) begin
        acx <= shx;
        acy <= shy;
      end
      if (bus.wea && bus.wselect == 4'hF) begin
        if (bus.waddr[3:2] == 2'd0 && bus.wdata[9:0] < 10'd640) shx <= bus.wdata[9:0];
        if (bus.waddr[3:2] == 2'd1 && bus.wdata[9:0] < 10'd480) shy <= bus.wdata[9:0];
        if (bus.waddr[3:2] == 2'd2) begin
          en <= bus.wdata[0];
          bg <= bus.wdata[27:16];
        end
      end
    end
  end
  assign act_v = {xi, yi, tex_addr, pix, ode, ohs, ovs};
  assign exp_v = {ex, ey, ea, ep, ede, ehs, evs};
  always @(negedge clk) begin
    n_chk  <= n_chk + int'(rst_n) + int'(lit_on);
    n_fail <= n_fail + int'(rst_n && act_v !== exp_v) + int'(lit_on && (act_v & lit_m) !== lit_x);
    if (rst_n && act_v !== exp_v)
      $display("FAIL model_cmp t=%0t: got idx=%0d,%0d addr=%h pix=%h de/hs/vs=%b%b%b want idx=%0d,%0d addr=%h pix=%h de/hs/vs=%b%b%b",
               $time, xi, yi, tex_addr, pix, ode, ohs, ovs, ex, ey, ea, ep, ede, ehs, evs);
    if (lit_on && (act_v & lit_m) !== lit_x)
      $display("FAIL %s t=%0t: got %h want %h (mask %h)", lit_nm, $time, act_v & lit_m, lit_x, lit_m);
  end
  task automatic cyc(input logic [9:0] x, y, input logic d, hh, vv);
    px = x;
    py = y;
    de = d;
    hs = hh;
    vs = vv;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic vrise();
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [1:0] w, input logic [31:0] d, input logic [3:0] s, input logic v);
    bus.waddr   = {23'h0, w, 2'b00};
    bus.wdata   = d;
    bus.wselect = s;
    bus.wea     = 1'b1;
    cyc(10'd0, 10'd0, 1'b0, 1'b0, v);
    bus.wea     = 1'b0;
  endtask
  task automatic lit(input string nm, input logic [42:0] m, input logic [42:0] x);
    lit_nm = nm;
    lit_m  = m;
    lit_x  = x;
    lit_on = 1'b1;
    @(negedge clk);
    #1;
    lit_on = 1'b0;
  endtask
  initial begin
    bus.wea = 1'b0;
    bus.wdata = '0;
    bus.wselect = '0;
    bus.waddr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(10'd17, 10'd33, 1'b1, 1'b0, 1'b0);
    lit("basic_idx", M_IDX, {6'd1, 6'd2, 31'h0});
    idle(2);
    lit("basic_addr", M_ADDR, {12'h0, 16'h5A11, 15'h0});
    idle(2);
    lit("basic_pix", M_PD, {28'h0, 12'hFB0, 3'b100});
    wr(2'd0, 32'd630, 4'hF, 1'b0);
    wr(2'd1, 32'd475, 4'hF, 1'b0);
    vrise();
    cyc(10'd15, 10'd10, 1'b1, 1'b0, 1'b0);
    lit("wrap_idx", M_IDX, 43'h0);
    idle(2);
    lit("wrap_addr_lo", M_ALO, {12'h0, 16'h0055, 15'h0});
    wr(2'd0, 32'd640, 4'hF, 1'b0);
    wr(2'd0, 32'd100, 4'h3, 1'b0);
    vrise();
    cyc(10'd15, 10'd10, 1'b1, 1'b0, 1'b0);
    lit("drop_idx", M_IDX, 43'h0);
    idle(2);
    lit("drop_addr_lo", M_ALO, {12'h0, 16'h0055, 15'h0});
    wr(2'd0, 32'd8, 4'hF, 1'b1);
    idle(1);
    cyc(10'd15, 10'd10, 1'b1, 1'b0, 1'b0);
    lit("same_cyc_idx", M_IDX, 43'h0);
    idle(2);
    lit("same_cyc_addr_lo", M_ALO, {12'h0, 16'h0055, 15'h0});
    vrise();
    cyc(10'd15, 10'd10, 1'b1, 1'b0, 1'b0);
    lit("next_frame_idx", M_IDX, {6'd1, 6'd0, 31'h0});
    idle(2);
    lit("next_frame_addr_lo", M_ALO, {12'h0, 16'h0057, 15'h0});
    wr(2'd2, 32'h0F0A_0000, 4'hF, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b1, 1'b0, 1'b0);
      if (k >= 5) lit("bg_pix", M_PD, {28'h0, 12'hF0A, 3'b100});
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b0, 1'b0, 1'b0);
      if (k >= 5) lit("blank_pix", M_PD, 43'h0);
    end
    wr(2'd2, 32'h0000_0001, 4'hF, 1'b0);
    for (int f = 0; f < 4; f++) begin
      int y0;
      y0 = (f == 0) ? 474 : int'($urandom_range(0, 474));
      for (int l = 0; l < 10; l++) begin
        for (int x = 0; x < 800; x++) begin
          if ($urandom_range(0, 63) == 0) begin
            bus.waddr   = 27'($urandom);
            bus.wselect = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            bus.wdata   = $urandom;
            bus.wdata[9:0] = 10'($urandom_range(0, 700));
            bus.wea     = 1'b1;
          end else bus.wea = 1'b0;
          cyc(10'(x), 10'(l < 6 ? y0 + l : 474 + l), l < 6 && x < 640, x >= 656 && x < 752, l == 7 || l == 8);
        end
      end
    end
    bus.wea = 1'b0;
    for (int k = 0; k < 10; k++) cyc(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    lit("reset_async", {43{1'b1}}, 43'h0);
    idle(3);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b1, 1'b0, 1'b0);
      lit("reset_latency", M_DE, k >= 5 ? 43'b100 : 43'b0);
    end
    idle(8);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
